// File: rtl/vliw_lsu_if.sv
// Bundle issue, memory bus and writeback signals of the VLIW load/store unit.
// The LSU connects through the slave modport; the core/memory side uses master.
interface vliw_lsu_if #(
   parameter int REG_IDX_W = 6,
   parameter int NSLOT     = 3
);
   logic                       req_valid;
   logic                       req_ready;
   logic [NSLOT-1:0]           is_load;
   logic [NSLOT-1:0]           is_store;
   logic [NSLOT-1:0]           sign_extend;
   logic [2*NSLOT-1:0]         ls_size;
   logic [32*NSLOT-1:0]        ls_addr;
   logic [32*NSLOT-1:0]        st_data;
   logic [REG_IDX_W*NSLOT-1:0] ls_dest;
   logic                       busy;

   logic                       mem_req;
   logic                       mem_we;
   logic [31:0]                mem_addr;
   logic [31:0]                mem_wdata;
   logic [3:0]                 mem_wmask;
   logic                       mem_ack;
   logic [31:0]                mem_rdata;

   logic                       wb_valid;
   logic [REG_IDX_W-1:0]       wb_idx;
   logic [31:0]                wb_data;
   logic                       misalign;

   modport slave (
      input  req_valid, is_load, is_store, sign_extend, ls_size, ls_addr, st_data, ls_dest,
      input  mem_ack, mem_rdata,
      output req_ready, busy,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output wb_valid, wb_idx, wb_data, misalign
   );

   modport master (
      output req_valid, is_load, is_store, sign_extend, ls_size, ls_addr, st_data, ls_dest,
      output mem_ack, mem_rdata,
      input  req_ready, busy,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  wb_valid, wb_idx, wb_data, misalign
   );
endinterface

// File: rtl/vliw_lsu.sv
// Load/store unit: serialises up to three slot memory ops of one VLIW bundle onto
// a single req/ack memory bus, in slot order, and returns formatted load writebacks.
module vliw_lsu #(
   parameter int REG_IDX_W = 6,
   parameter int NSLOT     = 3
) (
   input  logic       wb_clk_i,
   input  logic       rst,
   vliw_lsu_if.slave  bus
);
   localparam int SLOT_W = $clog2(NSLOT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [NSLOT-1:0]     r_pend;
   logic [NSLOT-1:0]     r_is_store;
   logic [NSLOT-1:0]     r_sext;
   logic [1:0]           r_size [NSLOT];
   logic [31:0]          r_addr [NSLOT];
   logic [31:0]          r_data [NSLOT];
   logic [REG_IDX_W-1:0] r_dest [NSLOT];
   logic [SLOT_W-1:0]    r_slot;

   logic                 r_req_ready;
   logic                 r_busy;
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [31:0]          r_mem_addr;
   logic [31:0]          r_mem_wdata;
   logic [3:0]           r_mem_wmask;
   logic                 r_wb_valid;
   logic [REG_IDX_W-1:0] r_wb_idx;
   logic [31:0]          r_wb_data;
   logic                 r_misalign;

   logic [NSLOT-1:0]     w_pend_in;
   logic [SLOT_W-1:0]    w_sel;
   logic [NSLOT-1:0]     w_sel_oh;
   logic [NSLOT-1:0]     w_slot_oh;
   logic [1:0]           w_sel_size;
   logic [31:0]          w_sel_addr;
   logic [31:0]          w_sel_data;
   logic                 w_misal;
   logic [31:0]          w_st_wdata;
   logic [3:0]           w_st_wmask;
   logic [1:0]           w_slot_lane;
   logic [31:0]          w_ld_shift;
   logic [31:0]          w_ld_data;

   assign w_pend_in = bus.is_load | bus.is_store;

   // Lowest pending slot wins, which gives slot-order serialisation.
   always_comb begin
      w_sel    = '0;
      w_sel_oh = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_sel    = SLOT_W'(i);
            w_sel_oh = NSLOT'(1) << i;
         end
      end
   end

   always_comb begin
      w_slot_oh = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (r_slot == SLOT_W'(i)) begin
            w_slot_oh[i] = 1'b1;
         end
      end
   end

   assign w_sel_size  = r_size[w_sel];
   assign w_sel_addr  = r_addr[w_sel];
   assign w_sel_data  = r_data[w_sel];
   assign w_slot_lane = r_addr[r_slot][1:0];

   always_comb begin
      w_misal    = 1'b0;
      w_st_wdata = w_sel_data;
      w_st_wmask = 4'hF;
      case (w_sel_size)
         2'd0: begin
            w_st_wdata = {4{w_sel_data[7:0]}};
            w_st_wmask = 4'b0001 << w_sel_addr[1:0];
         end
         2'd1: begin
            w_misal    = w_sel_addr[0];
            w_st_wdata = {2{w_sel_data[15:0]}};
            w_st_wmask = 4'b0011 << w_sel_addr[1:0];
         end
         default: begin
            w_misal    = |w_sel_addr[1:0];
         end
      endcase
      // A slot flagged both load and store runs as a store; pure loads read the whole word.
      if (!r_is_store[w_sel]) begin
         w_st_wdata = '0;
         w_st_wmask = 4'hF;
      end
   end

   // Word accesses are always aligned here, so the lane shift is zero for them.
   assign w_ld_shift = bus.mem_rdata >> {w_slot_lane, 3'b000};

   always_comb begin
      w_ld_data = w_ld_shift;
      case (r_size[r_slot])
         2'd0: w_ld_data = r_sext[r_slot] ? {{24{w_ld_shift[7]}}, w_ld_shift[7:0]}
                                          : {24'd0, w_ld_shift[7:0]};
         2'd1: w_ld_data = r_sext[r_slot] ? {{16{w_ld_shift[15]}}, w_ld_shift[15:0]}
                                          : {16'd0, w_ld_shift[15:0]};
         default: w_ld_data = w_ld_shift;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid && (|w_pend_in)) begin
               w_state_next = S_SCAN;
            end
         end
         S_SCAN: begin
            if (!w_misal) begin
               w_state_next = S_WAIT;
            end else if (|(r_pend & ~w_sel_oh)) begin
               w_state_next = S_SCAN;
            end else begin
               w_state_next = S_DONE;
            end
         end
         S_WAIT: begin
            if (bus.mem_ack && r_mem_req) begin
               w_state_next = (|(r_pend & ~w_slot_oh)) ? S_SCAN : S_DONE;
            end
         end
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         r_pend      <= '0;
         r_is_store  <= '0;
         r_sext      <= '0;
         r_slot      <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            r_size[i] <= '0;
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_dest[i] <= '0;
         end
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_idx    <= '0;
         r_wb_data   <= '0;
         r_misalign  <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_pend     <= w_pend_in;
                  r_is_store <= bus.is_store;
                  r_sext     <= bus.sign_extend;
                  for (int i = 0; i < NSLOT; i++) begin
                     r_size[i] <= bus.ls_size[2*i +: 2];
                     r_addr[i] <= bus.ls_addr[32*i +: 32];
                     r_data[i] <= bus.st_data[32*i +: 32];
                     r_dest[i] <= bus.ls_dest[REG_IDX_W*i +: REG_IDX_W];
                  end
                  if (|w_pend_in) begin
                     r_busy      <= 1'b1;
                     r_req_ready <= 1'b0;
                  end
               end
            end
            S_SCAN: begin
               if (w_misal) begin
                  r_misalign <= 1'b1;
                  r_pend     <= r_pend & ~w_sel_oh;
               end else begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= r_is_store[w_sel];
                  r_mem_addr  <= {w_sel_addr[31:2], 2'b00};
                  r_mem_wdata <= w_st_wdata;
                  r_mem_wmask <= w_st_wmask;
                  r_slot      <= w_sel;
               end
            end
            S_WAIT: begin
               if (bus.mem_ack && r_mem_req) begin
                  r_mem_req <= 1'b0;
                  r_pend    <= r_pend & ~w_slot_oh;
                  if (!r_is_store[r_slot]) begin
                     r_wb_valid <= 1'b1;
                     r_wb_idx   <= r_dest[r_slot];
                     r_wb_data  <= w_ld_data;
                  end
               end
            end
            S_DONE: begin
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.busy      = r_busy;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wmask = r_mem_wmask;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_idx    = r_wb_idx;
   assign bus.wb_data   = r_wb_data;
   assign bus.misalign  = r_misalign;

endmodule

// File: tb/tb_vliw_lsu.sv
// Self-checking bench for vliw_lsu: directed bundles plus random bundles, checked
// against a per-bundle model of the expected bus transactions and writebacks.
`timescale 1ns/1ps
module tb_vliw_lsu;
   localparam int REG_IDX_W = 6;
   localparam int NSLOT     = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vliw_lsu_if #(.REG_IDX_W(REG_IDX_W), .NSLOT(NSLOT)) bus ();

   vliw_lsu #(.REG_IDX_W(REG_IDX_W), .NSLOT(NSLOT)) dut (
      .wb_clk_i (clk),
      .rst      (rst),
      .bus      (bus)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] wbData;
      logic [3:0]  wmask;
      logic [5:0]  dest;
      int          gap;
   } op_t;

   op_t         expQ[$];
   int          expMis;
   int          checks   = 0;
   int          failures = 0;

   logic [2:0]  bLoad;
   logic [2:0]  bStore;
   logic [2:0]  bSext;
   logic [1:0]  bSize  [3];
   logic [31:0] bAddr  [3];
   logic [31:0] bData  [3];
   logic [31:0] bRdata [3];
   logic [5:0]  bDest  [3];

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Load result from the read word: pick the addressed lane(s), then extend.
   function automatic logic [31:0] fmtLoad(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
      int unsigned v;
      v = rd >> ((a % 4) * 8);
      if (sz == 2'd0) begin
         v = v % 256;
         if (sx && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v % 65536;
         if (sx && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Expected bus ops in slot order; gap counts misaligned slots skipped before each op.
   function automatic void buildExpect();
      int gap;
      gap    = 0;
      expMis = 0;
      expQ.delete();
      for (int s = 0; s < 3; s++) begin
         op_t         o;
         int unsigned off;
         if (!(bLoad[s] || bStore[s])) continue;
         off = bAddr[s] % 4;
         if ((bSize[s] == 2'd1 && (off % 2) == 1) || (bSize[s] >= 2'd2 && off != 0)) begin
            gap++;
            expMis++;
            continue;
         end
         o.we     = bStore[s];
         o.addr   = bAddr[s] - off;
         o.gap    = gap;
         o.dest   = bDest[s];
         o.rdata  = bRdata[s];
         o.wbData = '0;
         gap      = 0;
         if (bStore[s]) begin
            case (bSize[s])
               2'd0: begin
                  o.wdata = (bData[s] % 256) * 32'h0101_0101;
                  o.wmask = 4'(1 << off);
               end
               2'd1: begin
                  o.wdata = (bData[s] % 65536) * 32'h0001_0001;
                  o.wmask = 4'(3 << off);
               end
               default: begin
                  o.wdata = bData[s];
                  o.wmask = 4'hF;
               end
            endcase
         end else begin
            o.wdata  = '0;
            o.wmask  = 4'hF;
            o.wbData = fmtLoad(bRdata[s], bAddr[s], bSize[s], bSext[s]);
         end
         expQ.push_back(o);
      end
   endfunction

   task automatic clearBundle();
      bLoad  = '0;
      bStore = '0;
      bSext  = '0;
      for (int s = 0; s < 3; s++) begin
         bSize[s]  = '0;
         bAddr[s]  = '0;
         bData[s]  = '0;
         bRdata[s] = $urandom;
         bDest[s]  = '0;
      end
   endtask

   task automatic setSlot(input int s, input logic ld, input logic st, input logic sx,
                          input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input logic [5:0] dst, input logic [31:0] rd);
      bLoad[s]  = ld;
      bStore[s] = st;
      bSext[s]  = sx;
      bSize[s]  = sz;
      bAddr[s]  = a;
      bData[s]  = d;
      bDest[s]  = dst;
      bRdata[s] = rd;
   endtask

   task automatic randomBundle();
      for (int s = 0; s < 3; s++) begin
         int          kind;
         int unsigned off;
         logic [31:0] base;
         kind      = $urandom_range(0, 3);
         bLoad[s]  = (kind == 1 || kind == 3);
         bStore[s] = (kind >= 2);
         bSext[s]  = 1'($urandom);
         bSize[s]  = 2'($urandom);
         off       = $urandom_range(0, 3);
         if ($urandom_range(0, 2) != 0) begin
            if (bSize[s] == 2'd1) off = off & 2;
            else if (bSize[s] >= 2'd2) off = 0;
         end
         base      = $urandom;
         bAddr[s]  = (base & 32'hFFFF_FFFC) | off;
         bData[s]  = $urandom;
         bRdata[s] = $urandom;
         bDest[s]  = 6'($urandom);
      end
   endtask

   task automatic applyStimulus();
      bus.is_load     = bLoad;
      bus.is_store    = bStore;
      bus.sign_extend = bSext;
      for (int s = 0; s < 3; s++) begin
         bus.ls_size[2*s +: 2]  = bSize[s];
         bus.ls_addr[32*s +: 32] = bAddr[s];
         bus.st_data[32*s +: 32] = bData[s];
         bus.ls_dest[6*s +: 6]   = bDest[s];
      end
   endtask

   // Issue the current bundle, act as the memory, and check every cycle until idle.
   task automatic runBundle(input int fixLat);
      op_t         cur;
      int          cyc, lat, base, misSeen;
      logic        anyPend, inTxn, ackNow, realAck, wbDue, done;
      logic [5:0]  wbIdx;
      logic [31:0] wbDat;
      buildExpect();
      anyPend = (|bLoad) || (|bStore);
      @(negedge clk);
      applyStimulus();
      bus.req_valid = 1'b1;
      checkOutput("ready_at_issue", 32'(bus.req_ready), 1);
      cyc = 0; base = 0; misSeen = 0; lat = 0;
      inTxn = 1'b0; ackNow = 1'b0; realAck = 1'b0; wbDue = 1'b0; done = 1'b0;
      wbIdx = '0; wbDat = '0;
      cur = '{we: 1'b0, addr: '0, wdata: '0, rdata: '0, wbData: '0, wmask: '0, dest: '0, gap: 0};
      while (!done) begin
         @(negedge clk);
         cyc++;
         bus.req_valid = 1'b0;
         if (ackNow) begin
            bus.mem_ack = 1'b0;
            ackNow      = 1'b0;
         end
         checkOutput("wb_valid", 32'(bus.wb_valid), 32'(wbDue));
         if (wbDue && bus.wb_valid) begin
            checkOutput("wb_idx", 32'(bus.wb_idx), 32'(wbIdx));
            checkOutput("wb_data", bus.wb_data, wbDat);
         end
         wbDue = 1'b0;
         if (realAck) begin
            checkOutput("req_drop", 32'(bus.mem_req), 0);
            realAck = 1'b0;
         end
         if (bus.misalign) misSeen++;
         checkOutput("ready_vs_busy", 32'(bus.req_ready), 32'(!bus.busy));
         if (cyc == 1) checkOutput("busy_start", 32'(bus.busy), 32'(anyPend));
         if (bus.mem_req) begin
            if (!inTxn) begin
               if (expQ.size() == 0) begin
                  checkOutput("extra_req", 1, 0);
                  cur.we    = bus.mem_we;
                  cur.addr  = bus.mem_addr;
                  cur.wdata = bus.mem_wdata;
                  cur.wmask = bus.mem_wmask;
                  cur.rdata = '0;
               end else begin
                  cur = expQ.pop_front();
                  checkOutput("req_latency", cyc, base + 2 + cur.gap);
               end
               inTxn = 1'b1;
               lat   = (fixLat >= 0) ? fixLat : $urandom_range(0, 4);
            end
            checkOutput("mem_we", 32'(bus.mem_we), 32'(cur.we));
            checkOutput("mem_addr", bus.mem_addr, cur.addr);
            checkOutput("mem_wmask", 32'(bus.mem_wmask), 32'(cur.wmask));
            if (cur.we) checkOutput("mem_wdata", bus.mem_wdata, cur.wdata);
            if (lat == 0) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = cur.rdata;
               ackNow  = 1'b1;
               realAck = 1'b1;
               inTxn   = 1'b0;
               base    = cyc;
               if (!cur.we) begin
                  wbDue = 1'b1;
                  wbIdx = cur.dest;
                  wbDat = cur.wbData;
               end
            end else begin
               lat--;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
            ackNow        = 1'b1;
         end
         if (bus.busy && $urandom_range(0, 3) == 0) begin
            bus.req_valid = 1'b1;
            bus.is_load   = 3'($urandom);
            bus.is_store  = 3'($urandom);
            bus.ls_addr   = {$urandom, $urandom, $urandom};
         end
         if (cyc >= 3 && expQ.size() == 0 && !inTxn && !wbDue && !bus.busy) done = 1'b1;
         if (cyc > 400) begin
            checkOutput("timeout", 1, 0);
            done = 1'b1;
         end
      end
      bus.mem_ack   = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("ops_left", expQ.size(), 0);
      checkOutput("misalign_count", misSeen, expMis);
   endtask

   initial begin
      int n;
      rst             = 1'b1;
      bus.req_valid   = 1'b0;
      bus.is_load     = '0;
      bus.is_store    = '0;
      bus.sign_extend = '0;
      bus.ls_size     = '0;
      bus.ls_addr     = '0;
      bus.st_data     = '0;
      bus.ls_dest     = '0;
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_ready", 32'(bus.req_ready), 1);
      checkOutput("rst_mem_req", 32'(bus.mem_req), 0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 0);
      checkOutput("rst_mem_addr", bus.mem_addr, 0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
      checkOutput("rst_mem_wmask", 32'(bus.mem_wmask), 0);
      checkOutput("rst_wb_valid", 32'(bus.wb_valid), 0);
      checkOutput("rst_wb_idx", 32'(bus.wb_idx), 0);
      checkOutput("rst_wb_data", bus.wb_data, 0);
      checkOutput("rst_misalign", 32'(bus.misalign), 0);
      rst = 1'b0;

      clearBundle();
      setSlot(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 6'd5, 32'hDEAD_BEEF);
      runBundle(3);

      clearBundle();
      setSlot(0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0103, 32'h0, 6'd7, 32'h80FF_FF00);
      runBundle(1);
      clearBundle();
      setSlot(0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0103, 32'h0, 6'd8, 32'h80FF_FF00);
      runBundle(0);

      clearBundle();
      setSlot(0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0202, 32'h0000_1234, 6'd0, 32'h0);
      setSlot(1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0301, 32'h0000_00AB, 6'd0, 32'h0);
      setSlot(2, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 6'd9, 32'hCAFE_F00D);
      runBundle(2);

      clearBundle();
      setSlot(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0106, 32'h0, 6'd3, 32'h1111_1111);
      setSlot(2, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0500, 32'h1122_3344, 6'd0, 32'h0);
      runBundle(1);

      clearBundle();
      runBundle(0);

      // Reset in the middle of a transaction must drop it without a writeback.
      clearBundle();
      setSlot(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0600, 32'h0, 6'd3, 32'h1234_5678);
      @(negedge clk);
      applyStimulus();
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.mem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rst_test_req_seen", 32'(bus.mem_req), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_mid_mem_req", 32'(bus.mem_req), 0);
      checkOutput("rst_mid_busy", 32'(bus.busy), 0);
      checkOutput("rst_mid_ready", 32'(bus.req_ready), 1);
      checkOutput("rst_mid_wb_valid", 32'(bus.wb_valid), 0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("rst_late_wb_valid", 32'(bus.wb_valid), 0);
         checkOutput("rst_late_mem_req", 32'(bus.mem_req), 0);
         @(negedge clk);
      end
      clearBundle();
      setSlot(2, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_0702, 32'h0, 6'd44, 32'h8001_7FFF);
      runBundle(2);

      for (int t = 0; t < 60; t++) begin
         randomBundle();
         runBundle(-1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
